// File: rtl/ext_access_responder_pkg.sv
// Shared definitions for the external register-access responder:
// FSM state encodings, error codes, error read-data and node-index helper.
package ext_access_responder_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_RESP     = 2'd2;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE     = 2'd0;
    localparam err_code_t ERR_BAD_NODE = 2'd1;
    localparam err_code_t ERR_BOTH_EN  = 2'd2;
    localparam err_code_t ERR_TIMEOUT  = 2'd3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Mesh node index: row-major, y*size_x + x.
    function automatic logic [7:0] node_index(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic [4:0] size_x
    );
        logic [7:0] prod_v;
        prod_v = {4'h0, y} * {3'b000, size_x};
        return prod_v + {4'h0, x};
    endfunction

endpackage

// File: rtl/ext_access_responder.sv
// Target side of the external register-access interface: decodes the host
// request to one mesh node, runs a single register transaction, returns status.
module ext_access_responder
    import ext_access_responder_pkg::*;
#(
    parameter int          MESH_SIZE_X    = 2,
    parameter int          MESH_SIZE_Y    = 2,
    parameter int          NUM_NODES      = MESH_SIZE_X * MESH_SIZE_Y,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                    cpu_clk,
    input  logic                    rst,
    input  logic [7:0]              ext_node_select,
    input  logic [7:0]              ext_addr,
    input  logic                    ext_write_en,
    input  logic                    ext_read_en,
    input  logic [31:0]             ext_write_data,
    output logic [31:0]             ext_read_data,
    output logic                    ext_ready,
    output logic [NUM_NODES-1:0]    node_req,
    output logic                    node_we,
    output logic [7:0]              node_addr,
    output logic [31:0]             node_wdata,
    input  logic [NUM_NODES-1:0]    node_ack,
    input  logic [NUM_NODES*32-1:0] node_rdata,
    output logic                    err_valid,
    output logic [1:0]              err_code
);

    localparam int         IDX_W        = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [4:0] MESH_X_W     = 5'(MESH_SIZE_X);
    localparam logic [4:0] MESH_Y_W     = 5'(MESH_SIZE_Y);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [7:0]           cnt_r;
    logic [31:0]          read_data_r;
    logic                 ready_r;
    logic [NUM_NODES-1:0] node_req_r;
    logic                 node_we_r;
    logic [7:0]           node_addr_r;
    logic [31:0]          node_wdata_r;
    logic                 err_valid_r;
    err_code_t            err_code_r;

    logic [3:0]           x_s;
    logic [3:0]           y_s;
    logic                 any_en_s;
    logic                 both_en_s;
    logic                 bad_node_s;
    logic [IDX_W-1:0]     idx_s;
    logic [NUM_NODES-1:0] onehot_s;
    logic                 ack_hit_s;
    logic                 timeout_hit_s;
    logic [31:0]          rdata_sel_s;

    // Request decode and per-transaction selects driven from the latched index.
    always_comb begin
        x_s           = ext_node_select[7:4];
        y_s           = ext_node_select[3:0];
        any_en_s      = ext_write_en | ext_read_en;
        both_en_s     = ext_write_en & ext_read_en;
        bad_node_s    = ({1'b0, x_s} >= MESH_X_W) || ({1'b0, y_s} >= MESH_Y_W);
        idx_s         = IDX_W'(node_index(x_s, y_s, MESH_X_W));
        ack_hit_s     = node_ack[idx_r];
        timeout_hit_s = (cnt_r == TIMEOUT_LAST);
        rdata_sel_s   = node_rdata[{idx_r, 5'b00000} +: 32];
        onehot_s      = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            onehot_s[i] = (idx_s == IDX_W'(i));
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            cnt_r        <= 8'd0;
            read_data_r  <= 32'd0;
            ready_r      <= 1'b0;
            node_req_r   <= '0;
            node_we_r    <= 1'b0;
            node_addr_r  <= 8'd0;
            node_wdata_r <= 32'd0;
            err_valid_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    err_valid_r <= 1'b0;
                    if (any_en_s) begin
                        node_addr_r  <= ext_addr;
                        node_wdata_r <= ext_write_data;
                        node_we_r    <= ext_write_en;
                        idx_r        <= idx_s;
                        cnt_r        <= 8'd0;
                        if (bad_node_s) begin
                            state_r     <= ST_RESP;
                            ready_r     <= 1'b1;
                            read_data_r <= ERR_DATA;
                            err_code_r  <= ERR_BAD_NODE;
                            err_valid_r <= 1'b1;
                        end else if (both_en_s) begin
                            state_r     <= ST_RESP;
                            ready_r     <= 1'b1;
                            read_data_r <= ERR_DATA;
                            err_code_r  <= ERR_BOTH_EN;
                            err_valid_r <= 1'b1;
                        end else begin
                            state_r    <= ST_WAIT_ACK;
                            node_req_r <= onehot_s;
                            err_code_r <= ERR_NONE;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack in the same cycle as the timeout still completes normally.
                    if (ack_hit_s) begin
                        state_r     <= ST_RESP;
                        node_req_r  <= '0;
                        ready_r     <= 1'b1;
                        read_data_r <= node_we_r ? 32'd0 : rdata_sel_s;
                    end else if (timeout_hit_s) begin
                        state_r     <= ST_RESP;
                        node_req_r  <= '0;
                        ready_r     <= 1'b1;
                        read_data_r <= ERR_DATA;
                        err_code_r  <= ERR_TIMEOUT;
                        err_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    err_valid_r <= 1'b0;
                    if (!any_en_s) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    node_req_r  <= '0;
                    ready_r     <= 1'b0;
                    err_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ext_read_data = read_data_r;
    assign ext_ready     = ready_r;
    assign node_req      = node_req_r;
    assign node_we       = node_we_r;
    assign node_addr     = node_addr_r;
    assign node_wdata    = node_wdata_r;
    assign err_valid     = err_valid_r;
    assign err_code      = err_code_r;

endmodule

// File: tb/tb_ext_access_responder.sv
// Randomized self-checking bench for ext_access_responder on a 2x2 mesh.
module tb_ext_access_responder;

    localparam int MX = 2;
    localparam int MY = 2;
    localparam int NN = MX * MY;
    localparam int TO = 255;

    logic             cpu_clk = 1'b0;
    logic             rst;
    logic [7:0]       ext_node_select;
    logic [7:0]       ext_addr;
    logic             ext_write_en;
    logic             ext_read_en;
    logic [31:0]      ext_write_data;
    logic [31:0]      ext_read_data;
    logic             ext_ready;
    logic [NN-1:0]    node_req;
    logic             node_we;
    logic [7:0]       node_addr;
    logic [31:0]      node_wdata;
    logic [NN-1:0]    node_ack;
    logic [NN*32-1:0] node_rdata;
    logic             err_valid;
    logic [1:0]       err_code;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rd_mem [NN];

    ext_access_responder #(.MESH_SIZE_X(MX), .MESH_SIZE_Y(MY), .TIMEOUT_CYCLES(TO)) dut (
        .cpu_clk(cpu_clk), .rst(rst),
        .ext_node_select(ext_node_select), .ext_addr(ext_addr),
        .ext_write_en(ext_write_en), .ext_read_en(ext_read_en),
        .ext_write_data(ext_write_data), .ext_read_data(ext_read_data),
        .ext_ready(ext_ready), .node_req(node_req), .node_we(node_we),
        .node_addr(node_addr), .node_wdata(node_wdata), .node_ack(node_ack),
        .node_rdata(node_rdata), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic load_rdata(input int fixed_idx, input logic [31:0] fixed_val);
        for (int i = 0; i < NN; i++) begin
            rd_mem[i] = (i == fixed_idx) ? fixed_val : $urandom;
            node_rdata[32*i +: 32] = rd_mem[i];
        end
    endtask

    // One host transaction; ack_dly = 0 means the node never acknowledges.
    // Called and returns at a falling edge.
    task automatic do_txn(input logic [7:0] sel, input logic we, input logic re,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          input int ack_dly, input string tag);
        int x, y, idx, exp_err, exp_cyc, got_cyc, hold;
        logic [31:0] exp_data, first_data;
        logic [NN-1:0] exp_req;
        bit req_bad, side_bad, hold_bad;
        x = int'(sel[7:4]);
        y = int'(sel[3:0]);
        idx = y * MX + x;
        if (x >= MX || y >= MY) exp_err = 1;
        else if (we && re)      exp_err = 2;
        else if (ack_dly == 0)  exp_err = 3;
        else                    exp_err = 0;
        exp_data = (exp_err != 0) ? 32'hDEAD_BEEF : (we ? 32'd0 : rd_mem[idx]);
        if (exp_err == 1 || exp_err == 2) exp_cyc = 1;
        else if (exp_err == 3)            exp_cyc = TO + 1;
        else                              exp_cyc = ack_dly + 1;
        exp_req = (exp_err == 0 || exp_err == 3) ? NN'(1) << idx : '0;

        ext_node_select = sel; ext_addr = addr; ext_write_data = wdata;
        ext_write_en = we; ext_read_en = re;
        got_cyc = -1; req_bad = 1'b0; side_bad = 1'b0;
        for (int c = 1; c <= TO + 10 && got_cyc < 0; c++) begin
            @(negedge cpu_clk);
            node_ack = '0;
            if (ext_ready) begin
                got_cyc = c;
            end else begin
                if (node_req !== exp_req) req_bad = 1'b1;
                if (c == 1 && exp_req != '0 &&
                    (node_we !== we || node_addr !== addr || node_wdata !== wdata))
                    side_bad = 1'b1;
                if (c == 2) begin
                    ext_node_select = 8'($urandom); ext_addr = 8'($urandom);
                    ext_write_data = $urandom;
                end
                if (ack_dly != 0 && c == ack_dly) node_ack = exp_req;
                else if (c == 1 && ack_dly != 1) node_ack = NN'(1) << (idx ^ 1);
            end
        end
        n_cmp++;
        if (got_cyc !== exp_cyc) begin
            n_err++; $display("FAIL %s latency: got %0d cycles, want %0d", tag, got_cyc, exp_cyc);
        end
        n_cmp++;
        if (req_bad) begin
            n_err++; $display("FAIL %s node_req: last %b, want %b while waiting", tag, node_req, exp_req);
        end
        n_cmp++;
        if (side_bad) begin
            n_err++; $display("FAIL %s node_we/addr/wdata: got %b/%h/%h want %b/%h/%h",
                              tag, node_we, node_addr, node_wdata, we, addr, wdata);
        end
        n_cmp++;
        if (ext_read_data !== exp_data || err_code !== 2'(exp_err) || err_valid !== (exp_err != 0)) begin
            n_err++; $display("FAIL %s response: data %h code %0d errv %b, want %h %0d %b",
                              tag, ext_read_data, err_code, err_valid, exp_data, exp_err, exp_err != 0);
        end
        first_data = ext_read_data;
        hold = int'($urandom_range(1, 3));
        hold_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge cpu_clk);
            if (ext_ready !== 1'b1 || err_valid !== 1'b0 || ext_read_data !== first_data ||
                node_req !== '0 || node_addr !== addr)
                hold_bad = 1'b1;
        end
        n_cmp++;
        if (hold_bad) begin
            n_err++; $display("FAIL %s hold: ready %b errv %b data %h addr %h", tag,
                              ext_ready, err_valid, ext_read_data, node_addr);
        end
        ext_write_en = 1'b0; ext_read_en = 1'b0;
        @(negedge cpu_clk);
        n_cmp++;
        if (ext_ready !== 1'b0 || err_code !== 2'(exp_err) || node_req !== '0) begin
            n_err++; $display("FAIL %s release: ready %b code %0d req %b, want 0 %0d 0",
                              tag, ext_ready, err_code, node_req, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ext_node_select = 8'd0; ext_addr = 8'd0; ext_write_en = 1'b0; ext_read_en = 1'b0;
        ext_write_data = 32'd0; node_ack = '0;
        load_rdata(-1, 32'd0);
        #1;
        n_cmp++;
        if (ext_ready !== 1'b0 || ext_read_data !== 32'd0 || node_req !== '0 || node_we !== 1'b0 ||
            node_addr !== 8'd0 || node_wdata !== 32'd0 || err_valid !== 1'b0 || err_code !== 2'd0) begin
            n_err++; $display("FAIL reset_values: ready %b data %h req %b we %b addr %h wd %h ev %b ec %0d",
                              ext_ready, ext_read_data, node_req, node_we, node_addr, node_wdata,
                              err_valid, err_code);
        end
        @(negedge cpu_clk); @(negedge cpu_clk);
        rst = 1'b0;
        @(negedge cpu_clk);
    endtask

    task automatic test_write();
        load_rdata(-1, 32'd0);
        do_txn({4'd1, 4'd0}, 1'b1, 1'b0, 8'h01, 32'h3F00_0000, 3, "write_n10");
    endtask

    task automatic test_read();
        load_rdata(2, 32'h4120_0000);
        do_txn({4'd0, 4'd1}, 1'b0, 1'b1, 8'h03, 32'h0, 2, "read_n01");
    endtask

    task automatic test_bad_node();
        do_txn({4'd2, 4'd0}, 1'b0, 1'b1, 8'h10, 32'h0, 1, "bad_x");
        do_txn({4'd0, 4'd5}, 1'b1, 1'b0, 8'h11, 32'h1234_5678, 1, "bad_y");
    endtask

    task automatic test_both_en();
        do_txn({4'd1, 4'd1}, 1'b1, 1'b1, 8'h22, 32'hCAFE_F00D, 2, "both_en");
    endtask

    task automatic test_timeout();
        load_rdata(-1, 32'd0);
        do_txn({4'd1, 4'd1}, 1'b0, 1'b1, 8'h05, 32'h0, 0, "timeout");
    endtask

    task automatic test_rst_mid();
        ext_node_select = {4'd1, 4'd1}; ext_addr = 8'h44; ext_write_data = 32'h5555_AAAA;
        ext_read_en = 1'b0; ext_write_en = 1'b1;
        repeat (3) @(negedge cpu_clk);
        n_cmp++;
        if (node_req !== 4'b1000) begin
            n_err++; $display("FAIL rst_mid_pre: node_req %b, want 1000", node_req);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (node_req !== '0 || ext_ready !== 1'b0 || node_we !== 1'b0 || node_addr !== 8'd0 ||
            node_wdata !== 32'd0 || err_code !== 2'd0 || ext_read_data !== 32'd0) begin
            n_err++; $display("FAIL rst_mid_async: req %b ready %b we %b addr %h wd %h ec %0d, want all 0",
                              node_req, ext_ready, node_we, node_addr, node_wdata, err_code);
        end
        ext_write_en = 1'b0;
        @(negedge cpu_clk);
        rst = 1'b0;
        @(negedge cpu_clk);
        node_ack = 4'b1000;
        @(negedge cpu_clk);
        node_ack = '0;
        @(negedge cpu_clk);
        n_cmp++;
        if (ext_ready !== 1'b0 || node_req !== '0 || err_valid !== 1'b0 || ext_read_data !== 32'd0) begin
            n_err++; $display("FAIL rst_mid_late_ack: ready %b req %b errv %b data %h, want 0",
                              ext_ready, node_req, err_valid, ext_read_data);
        end
    endtask

    task automatic test_back_to_back();
        load_rdata(-1, 32'd0);
        do_txn({4'd0, 4'd0}, 1'b0, 1'b1, 8'h07, 32'h0, 1, "b2b_first");
        do_txn({4'd1, 4'd1}, 1'b1, 1'b0, 8'h08, 32'h8765_4321, 1, "b2b_second");
    endtask

    task automatic test_random();
        logic [3:0] x, y;
        logic we, re;
        int dly;
        for (int t = 0; t < 30; t++) begin
            load_rdata(-1, 32'd0);
            x = 4'($urandom_range(0, 2));
            y = 4'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0:       begin we = 1'b1; re = 1'b1; end
                1, 2:    begin we = 1'b1; re = 1'b0; end
                default: begin we = 1'b0; re = 1'b1; end
            endcase
            dly = int'($urandom_range(1, 12));
            do_txn({x, y}, we, re, 8'($urandom), $urandom, dly, $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_node();
        test_both_en();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
